// File: rtl/edge_filter_pkg.sv
// Shared constants and helpers for the RGB444 edge filter.
package edge_filter_pkg;

    localparam int IMG_WIDTH_DEF  = 320;
    localparam int IMG_HEIGHT_DEF = 240;

    localparam logic [2:0] MODE_BYPASS = 3'b000;
    localparam logic [2:0] MODE_K3     = 3'b001;
    localparam logic [2:0] MODE_K5     = 3'b010;

    localparam int PIX_W = 12;
    localparam int CH_W  = 4;
    localparam int CH_N  = 3;

    // Channel LSBs indexed R, G, B.
    localparam int CH_LSB [CH_N] = '{8, 4, 0};

    function automatic logic [2:0] decode_mode(input logic [2:0] ff);
        if (ff == MODE_K3 || ff == MODE_K5)
            return ff;
        return MODE_BYPASS;
    endfunction

    function automatic logic [CH_W-1:0] abs_clamp(input logic signed [11:0] s);
        logic [11:0] m;
        m = s[11] ? $unsigned(-s) : $unsigned(s);
        return (m > 12'd15) ? 4'hF : m[CH_W-1:0];
    endfunction

endpackage

// File: rtl/edge_filter_line_buffer.sv
// One video line of pixel storage; read is combinational so the
// previous row's pixel at this column is available on the same beat.
module line_buffer
    import edge_filter_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wr_data;
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/edge_filter.sv
// Streaming 3x3 / 5x5 Laplacian edge filter for RGB444 video,
// one register stage between input beat and output.
module edge_filter
    import edge_filter_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_in,
    input  logic        valid_in,
    input  logic        startofpacket_in,
    input  logic        endofpacket_in,
    input  logic [2:0]  freq_flag,
    input  logic [11:0] data_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic        startofpacket_out,
    output logic        endofpacket_out,
    output logic [11:0] data_out
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic             beat;
    logic [AW-1:0]    col_q, cur_col;
    logic [RW-1:0]    row_q, cur_row;
    logic [2:0]       mode_q, cur_mode;
    logic             is_k3, is_k5, border;
    logic [PIX_W-1:0] colv [5];
    logic [PIX_W-1:0] wq   [5][4];
    logic [PIX_W-1:0] win  [5][5];
    logic [PIX_W-1:0] kern, nxt_data;
    logic [9:0]       sum, cen;
    logic signed [11:0] s;

    assign ready_out = ready_in;
    assign beat      = valid_in && ready_in;

    // A sop beat is pixel (0,0) and carries the new frame's mode.
    assign cur_col  = startofpacket_in ? '0 : col_q;
    assign cur_row  = startofpacket_in ? '0 : row_q;
    assign cur_mode = startofpacket_in ? decode_mode(freq_flag) : mode_q;
    assign is_k3    = (cur_mode == MODE_K3);
    assign is_k5    = (cur_mode == MODE_K5);

    assign colv[0] = data_in;

    for (genvar k = 0; k < 4; k++) begin : g_lb
        line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb (
            .clk     (clk),
            .we      (beat),
            .addr    (cur_col),
            .wr_data (colv[k]),
            .rd_data (colv[k+1])
        );
    end

    // Index 0 is the newest row/column; the 3x3 sits in the [0..2] corner.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            win[i][0] = colv[i];
            for (int j = 0; j < 4; j++)
                win[i][j+1] = wq[i][j];
        end
    end

    always_comb begin
        kern = '0;
        sum  = '0;
        cen  = '0;
        s    = '0;
        for (int ch = 0; ch < CH_N; ch++) begin
            sum = '0;
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    if (is_k5 || (i < 3 && j < 3))
                        sum = sum + 10'(win[i][j][CH_LSB[ch] +: CH_W]);
            if (is_k5)
                cen = 10'(win[2][2][CH_LSB[ch] +: CH_W]) * 10'd25;
            else
                cen = 10'(win[1][1][CH_LSB[ch] +: CH_W]) * 10'd9;
            s = $signed({2'b00, cen}) - $signed({2'b00, sum});
            kern[CH_LSB[ch] +: CH_W] = abs_clamp(s);
        end
    end

    always_comb begin
        if (is_k5)
            border = (int'(cur_row) < 4) || (int'(cur_col) < 4);
        else
            border = (int'(cur_row) < 2) || (int'(cur_col) < 2);
    end

    always_comb begin
        nxt_data = data_in;
        unique case (1'b1)
            is_k3, is_k5: nxt_data = border ? '0 : kern;
            default:      nxt_data = data_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out         <= 1'b0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            data_out          <= '0;
            col_q             <= '0;
            row_q             <= '0;
            mode_q            <= MODE_BYPASS;
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 4; j++)
                    wq[i][j] <= '0;
        end else if (ready_in) begin
            valid_out         <= valid_in;
            startofpacket_out <= startofpacket_in && valid_in;
            endofpacket_out   <= endofpacket_in && valid_in;
            if (valid_in) begin
                data_out <= nxt_data;
                mode_q   <= cur_mode;
                if (cur_col == AW'(IMG_WIDTH - 1)) begin
                    col_q <= '0;
                    if (cur_row == RW'(IMG_HEIGHT - 1))
                        row_q <= '0;
                    else
                        row_q <= cur_row + 1'b1;
                end else begin
                    col_q <= cur_col + 1'b1;
                    row_q <= cur_row;
                end
                for (int i = 0; i < 5; i++) begin
                    wq[i][0] <= colv[i];
                    for (int j = 1; j < 4; j++)
                        wq[i][j] <= wq[i][j-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_filter.sv
// Randomized/directed bench for edge_filter against a frame-level model.
module tb_edge_filter;

    localparam int W = 16;
    localparam int H = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic [2:0]  freq_flag = 3'b000;
    logic [11:0] data_in = 12'h000;
    logic        ready_out, valid_out, sop_out, eop_out;
    logic [11:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [11:0] img [H][W];
    logic        exp_valid = 1'b0;
    logic        exp_sop = 1'b0;
    logic        exp_eop = 1'b0;
    logic [11:0] exp_data = 12'h000;

    edge_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk               (clk),
        .reset             (reset),
        .ready_in          (ready_in),
        .valid_in          (valid_in),
        .startofpacket_in  (sop_in),
        .endofpacket_in    (eop_in),
        .freq_flag         (freq_flag),
        .data_in           (data_in),
        .ready_out         (ready_out),
        .valid_out         (valid_out),
        .startofpacket_out (sop_out),
        .endofpacket_out   (eop_out),
        .data_out          (data_out)
    );

    always #5 clk = ~clk;

    // Output at (r,c) is the kernel centred on (r-rad, c-rad).
    function automatic logic [11:0] ref_px(input int mode, input int r, input int c);
        int rad, cen, nb, s;
        logic [11:0] res;
        if (mode != 1 && mode != 2)
            return img[r][c];
        rad = mode;
        if (r < 2 * rad || c < 2 * rad)
            return 12'h000;
        res = 12'h000;
        for (int ch = 0; ch < 3; ch++) begin
            cen = int'((img[r-rad][c-rad] >> (4 * ch)) & 12'hF);
            nb = 0;
            for (int dy = -rad; dy <= rad; dy++)
                for (int dx = -rad; dx <= rad; dx++)
                    if (dy != 0 || dx != 0)
                        nb += int'((img[r-rad+dy][c-rad+dx] >> (4 * ch)) & 12'hF);
            s = ((2 * rad + 1) * (2 * rad + 1) - 1) * cen - nb;
            if (s < 0) s = -s;
            if (s > 15) s = 15;
            res = res | (12'(s) << (4 * ch));
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %03h expected %03h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        check("valid_out", 12'(valid_out), 12'(exp_valid));
        check("sop_out", 12'(sop_out), 12'(exp_sop));
        check("eop_out", 12'(eop_out), 12'(exp_eop));
        check("data_out", data_out, exp_data);
    endtask

    task automatic step(input logic v, input logic rdy, input logic s, input logic e,
                        input logic [11:0] px, input logic [2:0] ff, input logic [11:0] want);
        @(negedge clk);
        check_outputs();
        valid_in = v;
        ready_in = rdy;
        sop_in = s;
        eop_in = e;
        data_in = px;
        freq_flag = ff;
        #1;
        check("ready_out", 12'(ready_out), 12'(rdy));
        if (rdy) begin
            exp_valid = v;
            exp_sop = s && v;
            exp_eop = e && v;
            if (v) exp_data = want;
        end
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 12'h555;
                    1: img[r][c] = (r % 5 == 0) ? 12'hFFF : 12'h000;
                    default: img[r][c] = 12'($urandom);
                endcase
    endtask

    task automatic send_frame(input int mode, input int gap, input int bp,
                              input bit rnd_ff, input int stall_at, input int abort_at);
        int idx;
        logic v, rdy, s, e;
        logic [2:0] ff;
        logic [11:0] want;
        idx = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (idx == abort_at) return;
                s = (r == 0 && c == 0);
                e = (r == H - 1 && c == W - 1);
                ff = (s || !rnd_ff) ? 3'(mode) : 3'($urandom_range(7));
                want = ref_px(mode, r, c);
                if (idx == stall_at)
                    repeat (10) step(1'b1, 1'b0, s, e, img[r][c], ff, want);
                for (int t = 0; t < 50; t++) begin
                    v = ($urandom_range(99) >= gap) || (t == 49);
                    rdy = ($urandom_range(99) >= bp) || (t == 49);
                    step(v, rdy, s, e, img[r][c], ff, want);
                    if (v && rdy) break;
                end
                idx++;
            end
        end
    endtask

    task automatic pre_sop_beats();
        logic [11:0] px;
        repeat (3) begin
            px = 12'($urandom);
            step(1'b1, 1'b1, 1'b0, 1'b0, px, 3'b001, px);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        pre_sop_beats();

        fill(0);
        send_frame(0, 0, 0, 1'b0, -1, -1);
        send_frame(1, 0, 0, 1'b0, -1, -1);
        send_frame(2, 0, 0, 1'b0, -1, -1);

        fill(1);
        send_frame(1, 0, 0, 1'b0, -1, -1);
        send_frame(2, 0, 0, 1'b0, -1, -1);
        send_frame(1, 0, 0, 1'b0, 40, -1);

        fill(2);
        send_frame(1, 20, 20, 1'b1, -1, -1);
        fill(2);
        send_frame(2, 20, 20, 1'b1, 77, -1);

        fill(2);
        send_frame(1, 10, 10, 1'b0, -1, 100);
        @(negedge clk);
        check_outputs();
        valid_in = 1'b0;
        sop_in = 1'b0;
        reset = 1'b1;
        #1;
        exp_valid = 1'b0;
        exp_sop = 1'b0;
        exp_eop = 1'b0;
        exp_data = 12'h000;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        pre_sop_beats();
        fill(2);
        send_frame(1, 10, 10, 1'b0, -1, -1);
        fill(1);
        send_frame(7, 0, 0, 1'b0, -1, -1);
        fill(2);
        send_frame(2, 0, 0, 1'b0, -1, -1);

        step(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 3'b000, 12'h000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 3'b000, 12'h000);
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
